aes_ct_offload_buffer: RTL

- Downstream neighbour of the multi-run controller in the pipelined AES-128 core.
- Captures each completed 128-bit ciphertext when the controller pulses perform_offload, and holds it in a small FIFO.
- Streams the stored blocks out as 32-bit words over a valid/ready handshake.
- Reports free space back to the controller as track_available, so the controller never offloads into a full buffer.

---
 rtl/aes_ct_offload_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/aes_ct_offload_buffer.sv
// Ciphertext offload FIFO for the pipelined AES-128 core: captures 128-bit blocks
// on perform_offload and streams them out MSW-first as 32-bit valid/ready words.
module aes_ct_offload_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             perform_offload,
    input  logic [127:0]     ct_in,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_valid,
    output logic             out_last,
    output logic             track_available,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [127:0]     entry [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       word_idx;
    logic [CNT_W-1:0] occ;
    logic             ovf;
    logic             push;
    logic             xfer;
    logic             pop;
    logic [127:0]     head;

    // Push is gated on the registered count, so a same-cycle pop never frees a slot early.
    assign track_available = (occ < FULL_CNT);
    assign out_valid       = (occ != '0);
    assign out_last        = out_valid && (word_idx == 2'd3);
    assign push            = perform_offload && track_available;
    assign xfer            = out_valid && out_ready;
    assign pop             = xfer && (word_idx == 2'd3);
    assign head            = entry[rd_ptr];
    assign count           = occ;
    assign overflow        = ovf;

    always_comb begin
        // NOTE: default first so every path assigns out_word and no latch is inferred.
        out_word = head[127:96];
        case (word_idx)
            2'd1:    out_word = head[95:64];
            2'd2:    out_word = head[63:32];
            2'd3:    out_word = head[31:0];
            default: out_word = head[127:96];
        endcase
    end

    // NOTE: storage is deliberately left out of reset; occ gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry[wr_ptr] <= ct_in;
        end
    end

    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            occ      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                word_idx <= word_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (perform_offload && !track_available) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
